sp_ram: RTL and testbench

SP_RAM -- requirements
Module: sp_ram

---
 rtl/sp_ram_pkg.sv | 12 +
 rtl/sp_ram_lane.sv | 46 ++++
 rtl/sp_ram.sv | 83 ++++++++
 tb/tb_sp_ram.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// Shared helpers for the sp_ram single-port RAM.
// clog2_min1: address width for a given word count, never less than one bit
// so a single-word RAM still has a real address port.
package sp_ram_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sp_ram_lane.sv
// One write-enable lane of sp_ram: LANEW bits of every word.
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   addr            - word address shared with the other lanes
//   in_range        - addr is below SIZE; gates both write and read
//   wren            - write enable for this lane
//   wdata / rdata   - this lane's slice of the write / read word
module sp_ram_lane #(
  parameter int unsigned      LANEW       = 1,
  parameter int unsigned      SIZE        = 1,
  parameter int unsigned      ADDRW       = 1,
  parameter int unsigned      INIT_ENABLE = 0,
  parameter logic [LANEW-1:0] INIT_VALUE  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADDRW-1:0] addr,
  input  logic             in_range,
  input  logic             wren,
  input  logic [LANEW-1:0] wdata,
  output logic [LANEW-1:0] rdata
);

  logic [LANEW-1:0] mem [SIZE];

  // Reset outranks writes; without INIT_ENABLE a reset cycle only blocks writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (INIT_ENABLE != 0) begin
        for (int unsigned i = 0; i < SIZE; i++) begin
          mem[i] <= INIT_VALUE;
        end
      end
    end else if (wren && in_range) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (in_range) begin
      rdata = mem[addr];
    end
  end

endmodule

// File: rtl/sp_ram.sv
// Single-port RAM, combinational (zero-latency) read, per-lane write enables.
// Parameters: DATAW word width, SIZE word count, BYTEENW write lanes,
//   NO_RWCHECK silences the simulation read-during-write warning,
//   INIT_ENABLE/INIT_VALUE make reset fill every word.
// Ports:
//   clk   - clock
//   reset - synchronous active-high reset
//   addr  - word address (read and write)
//   wren  - per-lane write enable, lane k covers bits [k*LANEW +: LANEW]
//   wdata - write data
//   rdata - read data, mem[addr], zero when addr >= SIZE
module sp_ram
  import sp_ram_pkg::*;
#(
  parameter int unsigned      DATAW       = 1,
  parameter int unsigned      SIZE        = 1,
  parameter int unsigned      BYTEENW     = 1,
  parameter int unsigned      NO_RWCHECK  = 0,
  parameter int unsigned      INIT_ENABLE = 0,
  parameter logic [DATAW-1:0] INIT_VALUE  = '0,
  localparam int unsigned     ADDRW       = clog2_min1(SIZE),
  localparam int unsigned     LANEW       = DATAW / BYTEENW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDRW-1:0]   addr,
  input  logic [BYTEENW-1:0] wren,
  input  logic [DATAW-1:0]   wdata,
  output logic [DATAW-1:0]   rdata
);

  generate
    if (BYTEENW < 1 || SIZE < 1 || (DATAW % BYTEENW) != 0) begin : g_bad_params
      $error("sp_ram: need SIZE >= 1, BYTEENW >= 1 and DATAW divisible by BYTEENW");
    end
  endgenerate

  localparam logic [ADDRW:0] SIZE_W = (ADDRW + 1)'(SIZE);

  logic in_range;

  always_comb begin
    in_range = ({1'b0, addr} < SIZE_W);
  end

  // Storage is split by lane so each lane's array has exactly one writer;
  // the word view mem[addr] is the concatenation of the lane arrays.
  for (genvar k = 0; k < BYTEENW; k++) begin : g_lane
    sp_ram_lane #(
      .LANEW      (LANEW),
      .SIZE       (SIZE),
      .ADDRW      (ADDRW),
      .INIT_ENABLE(INIT_ENABLE),
      .INIT_VALUE (INIT_VALUE[k*LANEW +: LANEW])
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .addr    (addr),
      .in_range(in_range),
      .wren    (wren[k]),
      .wdata   (wdata[k*LANEW +: LANEW]),
      .rdata   (rdata[k*LANEW +: LANEW])
    );
  end

`ifndef SYNTHESIS
  // Back-to-back writes to one address: the combinational read shows the
  // pre-edge word while the second write is set up, which is easy to misuse.
  if (NO_RWCHECK == 0) begin : g_rwcheck
    logic             prev_wr;
    logic [ADDRW-1:0] prev_addr;

    always_ff @(posedge clk) begin
      prev_wr   <= (|wren) && !reset;
      prev_addr <= addr;
      if (!reset && (|wren) && prev_wr && (addr == prev_addr)) begin
        $warning("sp_ram: read during write at address %0d", addr);
      end
    end
  end
`endif

endmodule

// File: tb/tb_sp_ram.sv
module tb_sp_ram;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // d1: 32x16, whole-word writes
  logic [3:0]  d1_addr = '0;
  logic        d1_wren = '0;
  logic [31:0] d1_wdata = '0;
  logic [31:0] d1_rdata;
  // d2: 32x16, four byte lanes
  logic [3:0]  d2_addr = '0;
  logic [3:0]  d2_wren = '0;
  logic [31:0] d2_wdata = '0;
  logic [31:0] d2_rdata;
  // d3: 16x8, reset fill 0xF0F0
  logic [2:0]  d3_addr = '0;
  logic        d3_wren = '0;
  logic [15:0] d3_wdata = '0;
  logic [15:0] d3_rdata;
  // d4: 8x12, non-power-of-two depth
  logic [3:0]  d4_addr = '0;
  logic        d4_wren = '0;
  logic [7:0]  d4_wdata = '0;
  logic [7:0]  d4_rdata;
  // d5: 64x16, eight byte lanes, random traffic
  logic [3:0]  d5_addr = '0;
  logic [7:0]  d5_wren = '0;
  logic [63:0] d5_wdata = '0;
  logic [63:0] d5_rdata;

  sp_ram #(.DATAW(32), .SIZE(16), .BYTEENW(1)) d1 (
    .clk(clk), .reset(reset), .addr(d1_addr), .wren(d1_wren), .wdata(d1_wdata), .rdata(d1_rdata));
  sp_ram #(.DATAW(32), .SIZE(16), .BYTEENW(4)) d2 (
    .clk(clk), .reset(reset), .addr(d2_addr), .wren(d2_wren), .wdata(d2_wdata), .rdata(d2_rdata));
  sp_ram #(.DATAW(16), .SIZE(8), .BYTEENW(1), .INIT_ENABLE(1), .INIT_VALUE(16'hF0F0)) d3 (
    .clk(clk), .reset(reset), .addr(d3_addr), .wren(d3_wren), .wdata(d3_wdata), .rdata(d3_rdata));
  sp_ram #(.DATAW(8), .SIZE(12), .BYTEENW(1)) d4 (
    .clk(clk), .reset(reset), .addr(d4_addr), .wren(d4_wren), .wdata(d4_wdata), .rdata(d4_rdata));
  sp_ram #(.DATAW(64), .SIZE(16), .BYTEENW(8), .NO_RWCHECK(1)) d5 (
    .clk(clk), .reset(reset), .addr(d5_addr), .wren(d5_wren), .wdata(d5_wdata), .rdata(d5_rdata));

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      d3_addr = 3'(a);
      #1;
      checks++;
      if (d3_rdata !== 16'hF0F0) begin
        errors++;
        $display("FAIL reset_fill addr=%0d got=%h want=f0f0", a, d3_rdata);
      end
    end
    d4_addr = 4'd13;
    #1;
    checks++;
    if (d4_rdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_oor_read got=%h want=00", d4_rdata);
    end
  endtask

  task automatic test_word_write;
    d1_addr = 4'd5; d1_wren = 1'b1; d1_wdata = 32'hDEADBEEF;
    tick();
    d1_wren = 1'b0; d1_wdata = '0;
    #1;
    checks++;
    if (d1_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_write got=%h want=deadbeef", d1_rdata);
    end
  endtask

  task automatic test_lane_write;
    d2_addr = 4'd2; d2_wren = 4'hF; d2_wdata = 32'h11223344;
    tick();
    d2_wren = 4'h0;
    tick();
    d2_wren = 4'b0101; d2_wdata = 32'hAABBCCDD;
    tick();
    d2_wren = 4'h0;
    #1;
    checks++;
    if (d2_rdata !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL lane_write got=%h want=11bb33dd", d2_rdata);
    end
    d2_addr = 4'd3;
    #1;
    d2_addr = 4'd2;
    #1;
    checks++;
    if (d2_rdata !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL lane_reread got=%h want=11bb33dd", d2_rdata);
    end
  endtask

  task automatic test_read_during_write;
    d1_addr = 4'd3; d1_wren = 1'b1; d1_wdata = 32'h0;
    tick();
    d1_wren = 1'b0;
    tick();
    d1_wren = 1'b1; d1_wdata = 32'h55;
    #1;
    checks++;
    if (d1_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rdw_before_edge got=%h want=00000000", d1_rdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if (d1_rdata !== 32'h55) begin
      errors++;
      $display("FAIL rdw_after_edge got=%h want=00000055", d1_rdata);
    end
    @(negedge clk);
    d1_wren = 1'b0;
  endtask

  task automatic test_reset_priority;
    d3_addr = 3'd7; d3_wren = 1'b1; d3_wdata = 16'h1234;
    d1_addr = 4'd9; d1_wren = 1'b1; d1_wdata = 32'hCAFEF00D;
    tick();
    d3_wren = 1'b0; d1_wren = 1'b0;
    #1;
    checks++;
    if (d3_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL prio_prewrite got=%h want=1234", d3_rdata);
    end
    tick();
    reset = 1'b1;
    d3_wren = 1'b1; d3_wdata = 16'hBEEF;
    d1_wren = 1'b1; d1_wdata = 32'h0;
    tick();
    reset = 1'b0; d3_wren = 1'b0; d1_wren = 1'b0;
    for (int a = 0; a < 8; a++) begin
      d3_addr = 3'(a);
      #1;
      checks++;
      if (d3_rdata !== 16'hF0F0) begin
        errors++;
        $display("FAIL prio_fill addr=%0d got=%h want=f0f0", a, d3_rdata);
      end
    end
    #1;
    checks++;
    if (d1_rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL reset_blocks_write got=%h want=cafef00d", d1_rdata);
    end
  endtask

  task automatic test_out_of_range;
    logic [7:0] model [12];
    for (int a = 0; a < 12; a++) begin
      model[a] = 8'($urandom);
      d4_addr = 4'(a); d4_wren = 1'b1; d4_wdata = model[a];
      tick();
    end
    d4_addr = 4'd13; d4_wren = 1'b1; d4_wdata = 8'h99;
    tick();
    d4_wren = 1'b0;
    #1;
    checks++;
    if (d4_rdata !== 8'h00) begin
      errors++;
      $display("FAIL oor_read13 got=%h want=00", d4_rdata);
    end
    for (int a = 0; a < 16; a++) begin
      d4_addr = 4'(a);
      #1;
      checks++;
      if (a < 12 && d4_rdata !== model[a]) begin
        errors++;
        $display("FAIL oor_keep addr=%0d got=%h want=%h", a, d4_rdata, model[a]);
      end else if (a >= 12 && d4_rdata !== 8'h00) begin
        errors++;
        $display("FAIL oor_zero addr=%0d got=%h want=00", a, d4_rdata);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] model [16];
    logic [63:0] want;
    int a;
    for (int i = 0; i < 16; i++) begin
      model[i] = {$urandom, $urandom};
      d5_addr = 4'(i); d5_wren = 8'hFF; d5_wdata = model[i];
      tick();
    end
    for (int n = 0; n < 1000; n++) begin
      a = $urandom_range(0, 15);
      d5_addr = 4'(a);
      d5_wren = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d5_wdata = {$urandom, $urandom};
      #1;
      checks++;
      if (d5_rdata !== model[a]) begin
        errors++;
        $display("FAIL rand_pre n=%0d addr=%0d got=%h want=%h", n, a, d5_rdata, model[a]);
      end
      // Byte k of the word takes the new data only where wren[k] is set.
      want = model[a];
      for (int k = 0; k < 8; k++) begin
        if (d5_wren[k]) want[k*8 +: 8] = d5_wdata[k*8 +: 8];
      end
      model[a] = want;
      @(posedge clk);
      #1;
      checks++;
      if (d5_rdata !== model[a]) begin
        errors++;
        $display("FAIL rand_post n=%0d addr=%0d got=%h want=%h", n, a, d5_rdata, model[a]);
      end
      @(negedge clk);
    end
    d5_wren = 8'h00;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_word_write();
    test_lane_write();
    test_read_during_write();
    test_reset_priority();
    test_out_of_range();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
